// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding an 8N1 UART serializer
`timescale 1ns/1ps

module uart_tx_arbiter #(
   parameter  int NREQ         = 4,
   parameter  int CLKS_PER_BIT = 868,
   localparam int GW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              uart_tx,
   output logic              busy,
   output logic [GW-1:0]     grant_id
);

   localparam int            BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        r_state, w_state_nxt;
   logic [BW-1:0] r_baud, w_baud_nxt;
   logic [2:0]    r_bit, w_bit_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic [GW-1:0] r_ptr, w_ptr_nxt;
   logic [GW-1:0] r_grant, w_grant_nxt;
   logic          r_tx, w_tx_nxt;
   logic          r_busy, w_busy_nxt;

   logic [7:0]      w_bytes [NREQ];
   logic [GW-1:0]   w_idx;
   logic [GW-1:0]   w_winner;
   logic            w_found;
   logic            w_baud_end;
   logic [NREQ-1:0] w_ready;

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign w_bytes[g] = req_data[8*g +: 8];
   end

   // Scan downward so the lowest offset from r_ptr is the last (winning) assignment.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = GW'((int'(r_ptr) + k) % NREQ);
         if (req_valid[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   assign w_baud_end = (r_baud == BAUD_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_ptr_nxt   = r_ptr;
      w_grant_nxt = r_grant;
      w_ready     = '0;
      case (r_state)
         S_IDLE: begin
            if (w_found && rst_n) begin
               w_ready[w_winner] = 1'b1;
               w_shift_nxt       = w_bytes[w_winner];
               w_grant_nxt       = w_winner;
               w_ptr_nxt         = GW'((int'(w_winner) + 1) % NREQ);
               w_baud_nxt        = '0;
               w_state_nxt       = S_START;
            end
         end
         S_START: begin
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_bit_nxt   = 3'd0;
               w_state_nxt = S_DATA;
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         S_DATA: begin
            if (w_baud_end) begin
               w_baud_nxt = '0;
               if (r_bit == 3'd7) begin
                  w_bit_nxt   = 3'd0;
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt   = r_bit + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
               end
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         S_STOP: begin
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Line value is derived from the next state so uart_tx stays a pure register output.
   always_comb begin
      w_tx_nxt   = 1'b1;
      w_busy_nxt = (w_state_nxt != S_IDLE);
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_ptr   <= '0;
         r_grant <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_ptr   <= w_ptr_nxt;
         r_grant <= w_grant_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign req_ready = w_ready;
   assign uart_tx   = r_tx;
   assign busy      = r_busy;
   assign grant_id  = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (NREQ=4, CLKS_PER_BIT=4)
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data  = '0;
   logic [3:0]  req_ready;
   logic        uart_tx;
   logic        busy;
   logic [1:0]  grant_id;

   logic [3:0]  persist = '0;
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          m_ptr = 0;
   logic [7:0]  exp_byte_q[$];
   logic [1:0]  exp_gid_q[$];

   uart_tx_arbiter #(.NREQ(4), .CLKS_PER_BIT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .uart_tx   (uart_tx),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // Expected line, index 0 = first cycle of the start bit.
   function automatic logic [39:0] frame_wave(input logic [7:0] b);
      return {4'hF, {4{b[7]}}, {4{b[6]}}, {4{b[5]}}, {4{b[4]}},
              {4{b[3]}}, {4{b[2]}}, {4{b[1]}}, {4{b[0]}}, 4'h0};
   endfunction

   // Round-robin reference: push the predicted winner and its byte.
   task automatic push_expect(input logic [3:0] v, output int w);
      logic [1:0]  idx;
      logic [31:0] sh;
      w = -1;
      for (int k = 0; k < 4; k++) begin
         idx = 2'((m_ptr + k) % 4);
         if (w < 0 && v[idx]) w = int'(idx);
      end
      if (w >= 0) begin
         sh = req_data >> (8 * w);
         exp_byte_q.push_back(sh[7:0]);
         exp_gid_q.push_back(2'(w));
         m_ptr = (w + 1) % 4;
      end
   endtask

   // One cycle: sample-safe point is negedge+1; accepted requesters drop valid.
   task automatic tick();
      logic [3:0] hs;
      #1;
      hs = req_valid & req_ready;
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         if (hs[i] && !persist[i]) req_valid[i] = 1'b0;
      #1;
   endtask

   task automatic wait_start(output bit to);
      to = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if (uart_tx === 1'b0) begin
            to = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic capture_frame(output logic [39:0] wave, output logic [39:0] bsy,
                                output logic [1:0] gid, output int ts, output bit to);
      wave = '0; bsy = '0; gid = '0; ts = 0;
      wait_start(to);
      if (!to) begin
         ts  = cyc;
         gid = grant_id;
         for (int i = 0; i < 40; i++) begin
            wave = {uart_tx, wave[39:1]};
            bsy  = {busy, bsy[39:1]};
            tick();
         end
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      req_valid = 4'hF;
      req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      repeat (3) tick();
      vectors++;
      if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", uart_tx); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++;
      if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_gid got %0d want 0", grant_id); end
      vectors++;
      if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got %b want 0000", req_ready); end
      rst_n = 1'b1;
      m_ptr = 0;
   endtask

   task automatic test_simultaneous();
      logic [39:0] wave, bsy;
      logic [1:0]  gid, eg;
      logic [7:0]  eb;
      logic [3:0]  m;
      int          ts, ts_prev, w;
      bit          to;
      #1;
      vectors++;
      if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL sim_first_ready got %b want 0001", req_ready); end
      m = 4'hF;
      for (int f = 0; f < 4; f++) begin
         push_expect(m, w);
         m[w] = 1'b0;
      end
      ts_prev = 0;
      for (int f = 0; f < 4; f++) begin
         capture_frame(wave, bsy, gid, ts, to);
         eb = exp_byte_q.pop_front();
         eg = exp_gid_q.pop_front();
         vectors++;
         if (to || wave !== frame_wave(eb)) begin miscompares++; $display("FAIL sim_wave[%0d] got %h want %h", f, wave, frame_wave(eb)); end
         vectors++;
         if (gid !== eg) begin miscompares++; $display("FAIL sim_gid[%0d] got %0d want %0d", f, gid, eg); end
         if (f > 0) begin
            vectors++;
            if (ts - ts_prev !== 41) begin miscompares++; $display("FAIL sim_spacing[%0d] got %0d want 41", f, ts - ts_prev); end
         end
         ts_prev = ts;
      end
   endtask

   task automatic test_fairness();
      logic [39:0] wave, bsy;
      logic [1:0]  gid, eg, prev;
      logic [7:0]  eb;
      int          ts, w;
      bit          to;
      req_data[7:0]   = 8'h40;
      req_data[23:16] = 8'h42;
      persist   = 4'b0101;
      req_valid = 4'b0101;
      for (int f = 0; f < 4; f++) push_expect(4'b0101, w);
      prev = 2'd3;
      for (int f = 0; f < 4; f++) begin
         if (f == 3) begin
            tick();
            persist   = '0;
            req_valid = '0;
         end
         capture_frame(wave, bsy, gid, ts, to);
         eb = exp_byte_q.pop_front();
         eg = exp_gid_q.pop_front();
         vectors++;
         if (to || wave !== frame_wave(eb)) begin miscompares++; $display("FAIL fair_wave[%0d] got %h want %h", f, wave, frame_wave(eb)); end
         vectors++;
         if (gid !== eg) begin miscompares++; $display("FAIL fair_gid[%0d] got %0d want %0d", f, gid, eg); end
         vectors++;
         if (gid === prev) begin miscompares++; $display("FAIL fair_repeat[%0d] got %0d want not %0d", f, gid, prev); end
         prev = gid;
      end
   endtask

   task automatic test_single_byte();
      logic [39:0] wave, bsy;
      logic [1:0]  gid, eg;
      logic [7:0]  eb;
      int          ts, w;
      bit          to;
      req_data[15:8] = 8'hA5;
      req_valid[1]   = 1'b1;
      push_expect(4'b0010, w);
      #1;
      vectors++;
      if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL single_ready got %b want 0010", req_ready); end
      capture_frame(wave, bsy, gid, ts, to);
      eb = exp_byte_q.pop_front();
      eg = exp_gid_q.pop_front();
      vectors++;
      if (to || wave !== frame_wave(eb)) begin miscompares++; $display("FAIL single_wave got %h want %h", wave, frame_wave(eb)); end
      vectors++;
      if (bsy !== {40{1'b1}}) begin miscompares++; $display("FAIL single_busy got %h want ffffffffff", bsy); end
      vectors++;
      if (gid !== eg) begin miscompares++; $display("FAIL single_gid got %0d want %0d", gid, eg); end
      vectors++;
      if (busy !== 1'b0 || uart_tx !== 1'b1 || req_ready !== 4'b0000) begin
         miscompares++;
         $display("FAIL single_after got busy=%b tx=%b ready=%b want 0 1 0000", busy, uart_tx, req_ready);
      end
   endtask

   task automatic test_withdrawn();
      logic [39:0] wave;
      logic [1:0]  gid, eg;
      logic [7:0]  eb;
      logic [3:0]  rdy_seen, idle_rdy;
      logic        tx_low, busy_seen;
      int          w;
      bit          to;
      req_data[7:0] = 8'h3C;
      req_valid[0]  = 1'b1;
      push_expect(4'b0001, w);
      wave = '0; rdy_seen = '0;
      wait_start(to);
      gid = grant_id;
      for (int i = 0; i < 40; i++) begin
         wave     = {uart_tx, wave[39:1]};
         rdy_seen = rdy_seen | req_ready;
         if (i == 10) begin req_valid[3] = 1'b1; req_data[31:24] = 8'hEE; end
         if (i == 30) req_valid[3] = 1'b0;
         tick();
      end
      eb = exp_byte_q.pop_front();
      eg = exp_gid_q.pop_front();
      vectors++;
      if (to || wave !== frame_wave(eb)) begin miscompares++; $display("FAIL wd_wave got %h want %h", wave, frame_wave(eb)); end
      vectors++;
      if (gid !== eg) begin miscompares++; $display("FAIL wd_gid got %0d want %0d", gid, eg); end
      vectors++;
      if (rdy_seen !== 4'b0000) begin miscompares++; $display("FAIL wd_ready_in_frame got %b want 0000", rdy_seen); end
      idle_rdy = '0; tx_low = 1'b0; busy_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         idle_rdy  = idle_rdy | req_ready;
         tx_low    = tx_low | ~uart_tx;
         busy_seen = busy_seen | busy;
         tick();
      end
      vectors++;
      if (idle_rdy !== 4'b0000) begin miscompares++; $display("FAIL wd_idle_ready got %b want 0000", idle_rdy); end
      vectors++;
      if (tx_low !== 1'b0) begin miscompares++; $display("FAIL wd_idle_tx got low=%b want 0", tx_low); end
      vectors++;
      if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL wd_idle_busy got %b want 0", busy_seen); end
   endtask

   task automatic test_ready_gating();
      logic [39:0] wave, bsy, wave2, bsy2;
      logic [1:0]  gid, gid2, eg;
      logic [7:0]  eb;
      logic [3:0]  stop_rdy;
      int          ts1, ts2, w;
      bit          to, to2;
      req_data[15:8] = 8'h81;
      req_valid[1]   = 1'b1;
      push_expect(4'b0010, w);
      wave = '0; bsy = '0; stop_rdy = '0; ts1 = 0;
      wait_start(to);
      ts1 = cyc;
      gid = grant_id;
      for (int i = 0; i < 40; i++) begin
         wave = {uart_tx, wave[39:1]};
         bsy  = {busy, bsy[39:1]};
         if (i == 36) begin
            req_valid[0]  = 1'b1;
            req_data[7:0] = 8'h5A;
            #1;
         end
         if (i >= 36) stop_rdy = stop_rdy | req_ready;
         tick();
      end
      eb = exp_byte_q.pop_front();
      eg = exp_gid_q.pop_front();
      vectors++;
      if (to || wave !== frame_wave(eb) || gid !== eg) begin
         miscompares++;
         $display("FAIL gate_frame1 got %h gid %0d want %h gid %0d", wave, gid, frame_wave(eb), eg);
      end
      vectors++;
      if (stop_rdy !== 4'b0000) begin miscompares++; $display("FAIL gate_stop_ready got %b want 0000", stop_rdy); end
      vectors++;
      if (req_ready !== 4'b0001 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL gate_idle got ready=%b busy=%b want 0001 0", req_ready, busy);
      end
      push_expect(4'b0001, w);
      capture_frame(wave2, bsy2, gid2, ts2, to2);
      eb = exp_byte_q.pop_front();
      eg = exp_gid_q.pop_front();
      vectors++;
      if (to2 || ts2 - ts1 !== 41) begin miscompares++; $display("FAIL gate_spacing got %0d want 41", ts2 - ts1); end
      vectors++;
      if (wave2 !== frame_wave(eb) || gid2 !== eg) begin
         miscompares++;
         $display("FAIL gate_frame2 got %h gid %0d want %h gid %0d", wave2, gid2, frame_wave(eb), eg);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [39:0] wave, bsy;
      logic [1:0]  gid, eg;
      logic [7:0]  eb;
      int          ts, w;
      bit          to;
      req_data[31:24] = 8'h86;
      req_valid[3]    = 1'b1;
      wait_start(to);
      repeat (21) tick();
      vectors++;
      if (to || uart_tx !== 1'b0) begin miscompares++; $display("FAIL rst_pre_bit4 got %b want 0", uart_tx); end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (uart_tx !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_async got tx=%b busy=%b want 1 0", uart_tx, busy);
      end
      vectors++;
      if (grant_id !== 2'd0) begin miscompares++; $display("FAIL rst_async_gid got %0d want 0", grant_id); end
      req_data[23:16] = 8'hC3;
      req_valid[2]    = 1'b1;
      #1;
      vectors++;
      if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_ready_gated got %b want 0000", req_ready); end
      repeat (2) tick();
      rst_n = 1'b1;
      m_ptr = 0;
      push_expect(4'b0100, w);
      capture_frame(wave, bsy, gid, ts, to);
      eb = exp_byte_q.pop_front();
      eg = exp_gid_q.pop_front();
      vectors++;
      if (to || wave !== frame_wave(eb)) begin miscompares++; $display("FAIL rst_after_wave got %h want %h", wave, frame_wave(eb)); end
      vectors++;
      if (gid !== eg) begin miscompares++; $display("FAIL rst_after_gid got %0d want %0d", gid, eg); end
      vectors++;
      if (bsy !== {40{1'b1}} || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_after_busy got %h end=%b want ffffffffff 0", bsy, busy);
      end
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_fairness();
      test_single_byte();
      test_withdrawn();
      test_ready_gating();
      test_reset_mid_frame();
      vectors++;
      if (exp_byte_q.size() !== 0) begin miscompares++; $display("FAIL scoreboard_leftover got %0d want 0", exp_byte_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
